// File: rtl/rv32_bus_pkg.sv
// Shared types and helpers for the rv32 instruction/data bus arbiter.
package rv32_bus_pkg;

    typedef enum logic {
        BUS_OWNER_INSTR = 1'b0,
        BUS_OWNER_DATA  = 1'b1
    } bus_owner_t;

    localparam int DEF_MAX_DATA_GRANTS = 4;
    localparam int DEF_TIMEOUT_CYCLES  = 1024;

    // Width of a counter that must hold values 0..max_val (at least one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rv32_bus_watchdog.sv
// Stall watchdog: counts cycles a granted transaction waits for ready and
// raises a sticky error once the limit is hit. Never touches the bus itself.
module rv32_bus_watchdog
    import rv32_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset_,
    input  logic active,
    input  logic ready,
    output logic timeout_error
);

    localparam int WD_W = cnt_w(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [WD_W-1:0] wd_cnt;
    logic            stalled;

    assign stalled = active & ~ready;

    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) begin
            wd_cnt        <= '0;
            timeout_error <= 1'b0;
        end else begin
            // Counter parks at its last value so it cannot wrap while a stall persists.
            if (!stalled) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_LAST) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if ((TIMEOUT_CYCLES != 0) && stalled && (wd_cnt == WD_LAST)) begin
                timeout_error <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rv32_bus_arbiter.sv
// Shares one memory bus between the rv32 fetch and load/store ports. Data has
// priority, bounded by a starvation counter; a granted transaction is locked until ready.
module rv32_bus_arbiter
    import rv32_bus_pkg::*;
#(
    parameter int MAX_DATA_GRANTS = DEF_MAX_DATA_GRANTS,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset_,
    input  logic [31:0] instr_address_in,
    input  logic        instr_read_in,
    output logic [31:0] instr_read_value_out,
    output logic        instr_ready_out,
    input  logic [31:0] data_address_in,
    input  logic        data_read_in,
    input  logic        data_write_in,
    input  logic [3:0]  data_write_mask_in,
    input  logic [31:0] data_write_value_in,
    output logic [31:0] data_read_value_out,
    output logic        data_ready_out,
    output logic [31:0] mem_address_out,
    output logic        mem_read_out,
    output logic        mem_write_out,
    output logic [3:0]  mem_write_mask_out,
    output logic [31:0] mem_write_value_out,
    input  logic [31:0] mem_read_value_in,
    input  logic        mem_ready_in,
    output logic        timeout_error_out
);

    localparam int STARVE_W = cnt_w(MAX_DATA_GRANTS);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_DATA_GRANTS);

    logic                busy;
    bus_owner_t          owner;
    logic [STARVE_W-1:0] starve_cnt;

    bus_owner_t winner;
    bus_owner_t sel_owner;
    logic       instr_req;
    logic       data_req;
    logic       sel_req;
    logic       sel_active;
    logic       sel_data;
    logic       done;

    always_comb begin
        instr_req = instr_read_in;
        data_req  = data_read_in | data_write_in;
        winner    = BUS_OWNER_INSTR;
        if (instr_req && data_req) begin
            winner = (starve_cnt == STARVE_MAX) ? BUS_OWNER_INSTR : BUS_OWNER_DATA;
        end else if (data_req) begin
            winner = BUS_OWNER_DATA;
        end
        sel_owner = busy ? owner : winner;
        sel_req   = (sel_owner == BUS_OWNER_DATA) ? data_req : instr_req;
        // Gating with reset makes the strobes fall as soon as reset asserts.
        sel_active = sel_req & ~reset_;
        sel_data   = sel_active & (sel_owner == BUS_OWNER_DATA);
        done       = sel_active & mem_ready_in;
    end

    assign mem_address_out      = !sel_active ? 32'h0 : (sel_data ? data_address_in : instr_address_in);
    assign mem_read_out         = sel_data ? data_read_in : sel_active;
    assign mem_write_out        = sel_data & data_write_in;
    assign mem_write_mask_out   = sel_data ? data_write_mask_in : 4'h0;
    assign mem_write_value_out  = sel_data ? data_write_value_in : 32'h0;
    assign instr_ready_out      = done & ~sel_data;
    assign data_ready_out       = done & sel_data;
    assign instr_read_value_out = mem_read_value_in;
    assign data_read_value_out  = mem_read_value_in;

    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) begin
            busy       <= 1'b0;
            owner      <= BUS_OWNER_INSTR;
            starve_cnt <= '0;
        end else begin
            // An abandoned or completed transaction both release the lock.
            if (sel_active && !mem_ready_in) begin
                busy  <= 1'b1;
                owner <= sel_owner;
            end else begin
                busy <= 1'b0;
            end
            if (done) begin
                if (sel_data && instr_req) begin
                    if (starve_cnt != STARVE_MAX) begin
                        starve_cnt <= starve_cnt + STARVE_W'(1);
                    end
                end else begin
                    starve_cnt <= '0;
                end
            end
        end
    end

    rv32_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk          (clk),
        .reset_       (reset_),
        .active       (sel_active),
        .ready        (mem_ready_in),
        .timeout_error(timeout_error_out)
    );

endmodule
